wb_uart_rx: RTL
===============

Name: wb_uart_rx

Overview:
Wishbone-slave UART receiver, the receive-side counterpart of wb_uart, which is transmit-only. It drives the currently unused uart_rx_i pin at soc level. It deserialises 8N1 frames, checks for framing errors, buffers received bytes in a small FIFO and exposes data, status and control registers. It also raises a level interrupt when data is available, so the CPU can poll or take an IRQ. The block sits on wb_mux as an additional slave port, alongside wb_uart.

Parameters:
WB_DATA_WIDTH, 32, Wishbone data width; only bits [7:0] and [2:0] carry payload.
WB_ADDR_WIDTH, 32, Wishbone address width; only wb_addr_i[3:2] is decoded.
CLKS_PER_BIT, 16, clk_i cycles per UART bit; minimum 4.
FIFO_DEPTH, 8, receive FIFO entries; power of two, minimum 2.

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
wb_addr_i  in  WB_ADDR_WIDTH  register address; bits [3:2] select the register
wb_data_i  in  WB_DATA_WIDTH  write data
wb_sel_i  in  4  byte select; ignored, all accesses are treated as full word
wb_we_i  in  1  write enable
wb_cyc_i  in  1  bus cycle
wb_stb_i  in  1  strobe
wb_ack_o  out  1  transfer acknowledge
wb_data_o  out  WB_DATA_WIDTH  read data
uart_rx_i  in  1  asynchronous serial input; idles high
rx_irq_o  out  1  level interrupt

Behaviour:
- Reset: clk_i only; rst_i synchronous, active-high.
  - Outputs: wb_ack_o=0, wb_data_o=0, rx_irq_o=0.
  - Internal: FIFO empty, frame_err=0, overrun=0, irq_en=0, FSM=IDLE, synchroniser flops=1.
  - Reset asserted mid-frame aborts the frame; no partial byte is pushed.
- Input sync: 2-flop synchroniser on uart_rx_i produces rx_s. All sampling uses rx_s.
- Bit counter: width clog2(CLKS_PER_BIT); bit index: 3 bits.
- FSM:
  - IDLE: rx_s==0 -> START, clk counter cleared.
  - START: at count CLKS_PER_BIT/2-1, sample rx_s. If 0 -> DATA with counter cleared. If 1 -> IDLE (glitch rejected, nothing recorded).
  - DATA: each time the counter reaches CLKS_PER_BIT-1, sample rx_s into shift reg (LSB first) and clear the counter. After the 8th bit -> STOP.
  - STOP: at count CLKS_PER_BIT-1, sample rx_s.
    - 1: push byte next cycle and go to IDLE.
    - 0: set frame_err, discard byte, go to BREAK.
  - BREAK: wait for rx_s==1, then -> IDLE. A held-low line never produces bytes.
- FIFO push:
  - Happens exactly 1 cycle after the valid stop sample.
  - If full and no simultaneous pop: byte dropped, overrun set, existing contents unchanged.
  - Push and pop in the same cycle: both take effect, count unchanged. This holds when full too, and no overrun is raised.
  - Pointers wrap modulo FIFO_DEPTH. Count is clog2(FIFO_DEPTH)+1 bits.
- Wishbone:
  - A request is cyc&stb&!ack. wb_ack_o is asserted for exactly 1 cycle, on the cycle after the request.
  - Back-to-back accesses therefore complete every 2 cycles.
  - wb_data_o is registered alongside ack and returns to 0 when ack=0.
  - Side effects (pop, clear) occur on the request cycle, once per access.
- Registers (wb_addr_i[3:2]):
  - 0 DATA, RO.
    - Read: {24'b0, head byte}, and pops.
    - Read when empty: returns 0, no pop, no flag change.
    - Writes are ignored but acked.
  - 1 STATUS.
    - Read: {29'b0, overrun, frame_err, !empty}.
    - Write: write-1-to-clear on bits 2:1.
    - A set event in the same cycle as a clear wins (the flag stays 1).
  - 2 CTRL, RW: bit0 irq_en; other bits read 0.
  - 3: reads 0, writes ignored, acked.
- rx_irq_o: registered; equals irq_en & (!empty | frame_err | overrun), 1-cycle lag.
- No error response; every request is acked.

Test Plan (CLKS_PER_BIT=16, FIFO_DEPTH=8):
1. Serial 0xA5 framed correctly -> STATUS reads 0x1; DATA reads 0x000000A5; STATUS then reads 0x0.
2. uart_rx_i low for 4 cycles, then high -> no push; STATUS stays 0x0; FSM back in IDLE.
3. 0x3C sent with stop bit 0 -> STATUS reads 0x2 and FIFO is empty. Write STATUS=0x2 -> reads 0x0. Line held low for 100 bit-times -> no bytes.
4. Nine bytes 0x01..0x09, no reads -> STATUS reads 0x5. Eight DATA reads return 0x01..0x08 in order; a ninth read returns 0. Write 0x4 -> STATUS 0x0.
5. CTRL=1, then 0x5A received -> rx_irq_o rises within 2 cycles of the push. It stays high until the DATA read, then falls 1 cycle later. With CTRL=0 it never rises.
6. rst_i asserted mid-DATA of 0xFF -> all outputs 0, FIFO empty. A following correct 0x11 frame is received as 0x11.

Source files
------------

// File: rtl/wb_uart_rx.sv
// Wishbone-slave 8N1 UART receiver with a small receive FIFO,
// status/control registers and a level interrupt.
module wb_uart_rx #(
    parameter int WB_DATA_WIDTH = 32,
    parameter int WB_ADDR_WIDTH = 32,
    parameter int CLKS_PER_BIT  = 16,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
    input  logic [3:0]               wb_sel_i,
    input  logic                     wb_we_i,
    input  logic                     wb_cyc_i,
    input  logic                     wb_stb_i,
    output logic                     wb_ack_o,
    output logic [WB_DATA_WIDTH-1:0] wb_data_o,
    input  logic                     uart_rx_i,
    output logic                     rx_irq_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t state_q, state_d;

    logic          rx_meta, rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          push_pend;
    logic          mid_hit, end_hit;
    logic          cnt_clr, shift_en, push_set, ferr_set;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          empty, full, push_do, pop;

    logic          frame_err, overrun, irq_en;
    logic          req, sel_data, sel_stat, sel_ctrl;
    logic          clr_ferr, clr_ovr, ovr_set;
    logic [WB_DATA_WIDTH-1:0] rdata;
    logic          unused_ok;

    assign unused_ok = ^{wb_sel_i, wb_addr_i, wb_data_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx_i;
            rx_s    <= rx_meta;
        end
    end

    assign mid_hit = (cnt == CNT_MID);
    assign end_hit = (cnt == CNT_END);

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (!rx_s) state_d = S_START;
            S_START: if (mid_hit) state_d = rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (end_hit && bit_idx == 3'd7) state_d = S_STOP;
            S_STOP:  if (end_hit) state_d = rx_s ? S_IDLE : S_BREAK;
            S_BREAK: if (rx_s) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_clr  = 1'b0;
        shift_en = 1'b0;
        push_set = 1'b0;
        ferr_set = 1'b0;
        unique case (state_q)
            S_IDLE:  cnt_clr = 1'b1;
            S_START: cnt_clr = mid_hit;
            S_DATA: begin
                cnt_clr  = end_hit;
                shift_en = end_hit;
            end
            S_STOP: begin
                cnt_clr  = end_hit;
                push_set = end_hit & rx_s;
                ferr_set = end_hit & ~rx_s;
            end
            S_BREAK: cnt_clr = 1'b1;
            default: cnt_clr = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            push_pend <= 1'b0;
        end else begin
            cnt       <= cnt_clr ? '0 : cnt + CW'(1);
            push_pend <= push_set;
            if (state_q == S_IDLE) bit_idx <= '0;
            if (shift_en) begin
                shreg   <= {rx_s, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    assign req      = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign sel_data = (wb_addr_i[3:2] == 2'd0);
    assign sel_stat = (wb_addr_i[3:2] == 2'd1);
    assign sel_ctrl = (wb_addr_i[3:2] == 2'd2);

    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign pop     = req & ~wb_we_i & sel_data & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_do = push_pend & (~full | pop);
    assign ovr_set = push_pend & full & ~pop;

    assign clr_ferr = req & wb_we_i & sel_stat & wb_data_i[1];
    assign clr_ovr  = req & wb_we_i & sel_stat & wb_data_i[2];

    always_ff @(posedge clk_i) begin
        if (push_do) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_do) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            unique case ({push_do, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            irq_en    <= 1'b0;
        end else begin
            if (ferr_set)      frame_err <= 1'b1;
            else if (clr_ferr) frame_err <= 1'b0;
            if (ovr_set)       overrun <= 1'b1;
            else if (clr_ovr)  overrun <= 1'b0;
            if (req && wb_we_i && sel_ctrl) irq_en <= wb_data_i[0];
        end
    end

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            sel_data: rdata[7:0] = empty ? 8'h00 : mem[rd_ptr];
            sel_stat: rdata[2:0] = {overrun, frame_err, ~empty};
            sel_ctrl: rdata[0]   = irq_en;
            default:  rdata      = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb_ack_o  <= 1'b0;
            wb_data_o <= '0;
            rx_irq_o  <= 1'b0;
        end else begin
            wb_ack_o  <= req;
            wb_data_o <= req ? rdata : '0;
            rx_irq_o  <= irq_en & (~empty | frame_err | overrun);
        end
    end

endmodule
